pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage RV32 core. It decides each cycle whether PC, IF/ID, ID/EX and EX/MEM advance, stall or flush, and emits the `id_ex_flush` consumed by the ID/EX register. It covers four cases: load-use hazards, taken branches/jumps resolved in EX, multi-cycle EX operations, and data-memory wait states. A watchdog flags stalls that never end.

---
 rtl/pipe_hazard_ctrl_if.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the pipeline-side hazard inputs and the stall/flush controls of
// the 5-stage RV32 sequencing controller.
//   master : pipeline datapath (drives hazard info, consumes stall/flush)
//   slave  : pipe_hazard_ctrl  (consumes hazard info, drives stall/flush)
// Signals:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : source operands of the ID instr
//   ex_rd, ex_mem_read                   : destination / load flag in EX
//   ex_br_taken                          : taken branch/jump resolved in EX
//   ex_mc_start, ex_mc_done              : multi-cycle EX unit handshake
//   mem_req, mem_ready                   : data-memory access handshake
//   *_stall, *_flush                     : per-register hold / bubble
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_br_taken;
  logic       ex_mc_start;
  logic       ex_mc_done;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       ex_mem_stall;
  logic       ex_mem_flush;
  logic       mem_wb_flush;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_br_taken, ex_mc_start, ex_mc_done, mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, ex_mem_flush, mem_wb_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_br_taken, ex_mc_start, ex_mc_done, mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, ex_mem_flush, mem_wb_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencing controller: decides every cycle whether PC, IF/ID,
// ID/EX and EX/MEM advance, hold or take a bubble. Handles load-use
// hazards, taken branches resolved in EX, multi-cycle EX operations and
// data-memory wait states, with a sticky watchdog on over-long waits.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   bus (slave)      : hazard inputs and stall/flush outputs
//   o_ctrl_state     : 0 RUN, 1 MC_WAIT, 2 MEM_WAIT
//   o_wd_err         : sticky watchdog error (cleared only by reset)
//   o_stall_cnt,
//   o_flush_cnt      : performance counters, only when the macro
//                      PIPE_HAZARD_CTRL_PERF_EN is defined
// Stall/flush outputs are combinational (same-cycle response); state,
// wait counter and watchdog are registered.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 64
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  pipe_hazard_ctrl_if.slave       bus,
  output logic [1:0]              o_ctrl_state,
  output logic                    o_wd_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]        o_stall_cnt,
  output logic [CNT_W-1:0]        o_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] LP_WAIT_MAX  = 16'(WAIT_MAX);
  localparam logic [15:0] LP_WAIT_LAST = 16'(WAIT_MAX - 1);

  state_t      r_state;
  logic        r_mc_pending;
  logic        r_mc_done_seen;
  logic        r_wd_err;
  logic [15:0] r_wait_cnt;

  logic        w_lu;
  logic        w_mem_hold;
  logic        w_freeze;
  logic        w_mc_hold;
  logic [15:0] w_wait_inc;

  logic        w_pc_stall;
  logic        w_if_id_stall;
  logic        w_if_id_flush;
  logic        w_id_ex_stall;
  logic        w_id_ex_flush;
  logic        w_ex_mem_stall;
  logic        w_ex_mem_flush;
  logic        w_mem_wb_flush;

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign w_lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                 (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  assign w_mem_hold = bus.mem_req && !bus.mem_ready;
  // The release cycle of MEM_WAIT is still frozen: freeze is state-based.
  assign w_freeze   = (r_state == ST_MEM_WAIT) || w_mem_hold;
  assign w_mc_hold  = ((r_state == ST_MC_WAIT) && !bus.ex_mc_done) ||
                      ((r_state == ST_RUN) && bus.ex_mc_start);
  assign w_wait_inc = (r_wait_cnt < LP_WAIT_MAX) ? (r_wait_cnt + 16'd1) : r_wait_cnt;

  // Priority decode of the stall/flush controls from state and live inputs.
  always_comb begin
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_mem_wb_flush = 1'b0;
    if (i_rst) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_flush = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (w_freeze) begin
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (w_mc_hold) begin
      // EX keeps iterating; EX/MEM receives bubbles meanwhile.
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_flush = 1'b1;
    end else if (bus.ex_br_taken) begin
      // Redirect squashes the two younger instructions; a load-use
      // match on the squashed ID instruction is irrelevant.
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
    end else if (w_lu) begin
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_flush  = 1'b1;
    end else begin
      w_pc_stall     = 1'b0;
    end
  end

  assign bus.pc_stall     = w_pc_stall;
  assign bus.if_id_stall  = w_if_id_stall;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_stall  = w_id_ex_stall;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_stall = w_ex_mem_stall;
  assign bus.ex_mem_flush = w_ex_mem_flush;
  assign bus.mem_wb_flush = w_mem_wb_flush;

  // Sequencing FSM with wait counter and sticky watchdog.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_RUN;
      r_mc_pending   <= 1'b0;
      r_mc_done_seen <= 1'b0;
      r_wd_err       <= 1'b0;
      r_wait_cnt     <= 16'd0;
    end else begin
      if ((r_state != ST_RUN) && (r_wait_cnt == LP_WAIT_LAST)) begin
        r_wd_err <= 1'b1;
      end
      case (r_state)
        ST_RUN: begin
          r_wait_cnt <= 16'd0;
          if (w_mem_hold) begin
            // A simultaneous mc_start stays held in EX and is seen again
            // once the memory freeze releases.
            r_state <= ST_MEM_WAIT;
          end else if (bus.ex_mc_start) begin
            r_state <= ST_MC_WAIT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_MC_WAIT: begin
          if (w_mem_hold) begin
            r_state        <= ST_MEM_WAIT;
            r_mc_pending   <= 1'b1;
            r_mc_done_seen <= bus.ex_mc_done;
            r_wait_cnt     <= w_wait_inc;
          end else if (bus.ex_mc_done) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 16'd0;
          end else begin
            r_wait_cnt <= w_wait_inc;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.mem_ready) begin
            r_mc_pending   <= 1'b0;
            r_mc_done_seen <= 1'b0;
            // Resume the multi-cycle wait only if its result never arrived.
            if (r_mc_pending && !(r_mc_done_seen || bus.ex_mc_done)) begin
              r_state    <= ST_MC_WAIT;
              r_wait_cnt <= w_wait_inc;
            end else begin
              r_state    <= ST_RUN;
              r_wait_cnt <= 16'd0;
            end
          end else begin
            r_mc_done_seen <= r_mc_done_seen || bus.ex_mc_done;
            r_wait_cnt     <= w_wait_inc;
          end
        end
        default: begin
          r_state        <= ST_RUN;
          r_mc_pending   <= 1'b0;
          r_mc_done_seen <= 1'b0;
          r_wait_cnt     <= 16'd0;
        end
      endcase
    end
  end

  assign o_ctrl_state = r_state;
  assign o_wd_err     = r_wd_err;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Free-running stall/flush event counters, wrapping naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_id_ex_flush) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule
